// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 host controller.
//   state_e     : controller FSM state encoding (4 bits)
//   DEF_*_US    : default timing values in microseconds
//   FRAME_BITS  : number of data bits in one sensor frame
//   frame_t     : 40-bit frame, first byte on the wire in the top bits
//   frame_sum   : 8-bit wrap-around sum of the four payload bytes
package dht11_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_LOW = 4'd1,
    ST_RELEASE   = 4'd2,
    ST_WAIT_RESP = 4'd3,
    ST_RESP_LOW  = 4'd4,
    ST_RESP_HIGH = 4'd5,
    ST_BIT_LOW   = 4'd6,
    ST_BIT_HIGH  = 4'd7,
    ST_CHECK     = 4'd8,
    ST_ERROR     = 4'd9
  } state_e;

  localparam int DEF_START_LOW_US  = 18_000;
  localparam int DEF_RELEASE_US    = 30;
  localparam int DEF_BIT_THRESH_US = 40;
  localparam int DEF_TIMEOUT_US    = 255;
  localparam int FRAME_BITS        = 40;

  // Bits arrive MSB first, so after 40 left shifts the first wire byte
  // (humidity integer) sits in the most significant position.
  typedef struct packed {
    logic [7:0] hum_inc;
    logic [7:0] hum_dec;
    logic [7:0] temp_inc;
    logic [7:0] temp_dec;
    logic [7:0] checksum;
  } frame_t;

  function automatic logic [7:0] frame_sum(input frame_t f);
    return f.hum_inc + f.hum_dec + f.temp_inc + f.temp_dec;
  endfunction

endpackage

// File: rtl/dht11_controller_tick_gen.sv
// 1 us tick generator.
//   clk    : system clock
//   rst    : synchronous, active-low reset
//   o_tick : one-cycle pulse every CLK_FREQ_HZ/1e6 clock cycles
module tick_gen_1us #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  // A clock slower than 1 MHz degenerates to a tick every cycle.
  localparam int DIV = (CLK_FREQ_HZ / 1_000_000 > 1) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == LAST);
    cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/dht11_controller.sv
// DHT11 single-wire host: start pulse, response timing, 40-bit capture,
// checksum verification and output byte registers.
//   clk, rst         : system clock, synchronous active-low reset
//   start            : one-cycle measurement request (ignored while busy/valid)
//   dht_io           : open-drain data line, driven 0 or released (external pull-up)
//   humidity_inc/dec : humidity bytes of the last good frame
//   temperature_inc/dec : temperature bytes of the last good frame
//   busy             : high in every state except IDLE
//   valid            : one-cycle pulse when a good frame is latched
//   error            : sticky failure flag, cleared when a new start is accepted
module dht11_controller
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_LOW_US  = DEF_START_LOW_US,
  parameter int RELEASE_US    = DEF_RELEASE_US,
  parameter int BIT_THRESH_US = DEF_BIT_THRESH_US,
  parameter int TIMEOUT_US    = DEF_TIMEOUT_US
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  inout  wire        dht_io,
  output logic [7:0] humidity_inc,
  output logic [7:0] humidity_dec,
  output logic [7:0] temperature_inc,
  output logic [7:0] temperature_dec,
  output logic       busy,
  output logic       valid,
  output logic       error
);

  localparam logic [15:0] START_LOW_CNT = 16'(START_LOW_US);
  localparam logic [15:0] RELEASE_CNT   = 16'(RELEASE_US);
  localparam logic [15:0] THRESH_CNT    = 16'(BIT_THRESH_US);
  localparam logic [15:0] TIMEOUT_CNT   = 16'(TIMEOUT_US);
  localparam logic [5:0]  LAST_BIT      = 6'(FRAME_BITS - 1);

  logic tick;

  tick_gen_1us #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (tick)
  );

  // Two-flop synchronizer plus one history flop for edge detection.
  // Reset to 1 (idle line level) so leaving reset creates no false edge.
  logic sync1_q, sync2_q, prev_q;
  logic rise, fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= dht_io;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  bit_idx_q, bit_idx_d;
  frame_t      shift_q, shift_d;
  frame_t      out_q, out_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        drive_low_q, drive_low_d;

  logic [15:0] high_len;
  logic        bit_one;
  logic        timeout;

  always_comb begin
    // The current cycle's tick is included so the measured high length
    // equals the exact number of ticks spanned by the high phase.
    high_len = cnt_q + {15'd0, tick};
    bit_one  = (high_len >= THRESH_CNT);
    timeout  = (cnt_q >= TIMEOUT_CNT);

    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    out_d     = out_q;
    error_d   = error_q;
    valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // valid_q high means the frame was just latched; a start in that
        // same cycle is dropped rather than chained.
        if (start && !busy_q && !valid_q) begin
          state_d = ST_START_LOW;
          error_d = 1'b0;
        end
      end
      ST_START_LOW: if (cnt_q >= START_LOW_CNT) state_d = ST_RELEASE;
      ST_RELEASE:   if (cnt_q >= RELEASE_CNT)   state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        if (fall)         state_d = ST_RESP_LOW;
        else if (timeout) state_d = ST_ERROR;
      end
      ST_RESP_LOW: begin
        if (rise)         state_d = ST_RESP_HIGH;
        else if (timeout) state_d = ST_ERROR;
      end
      ST_RESP_HIGH: begin
        if (fall) begin
          state_d   = ST_BIT_LOW;
          bit_idx_d = '0;
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_BIT_LOW: begin
        if (rise)         state_d = ST_BIT_HIGH;
        else if (timeout) state_d = ST_ERROR;
      end
      ST_BIT_HIGH: begin
        if (fall) begin
          shift_d = {shift_q[FRAME_BITS-2:0], bit_one};
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_CHECK;
          end else begin
            state_d   = ST_BIT_LOW;
            bit_idx_d = bit_idx_q + 6'd1;
          end
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_CHECK: begin
        if (frame_sum(shift_q) == shift_q.checksum) begin
          out_d   = shift_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Phase counter restarts on every state change and rests at 0 in IDLE.
    if (state_d != state_q || state_d == ST_IDLE) cnt_d = '0;
    else if (tick)                                cnt_d = cnt_q + 16'd1;
    else                                          cnt_d = cnt_q;

    busy_d      = (state_d != ST_IDLE);
    drive_low_d = (state_d == ST_START_LOW);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      drive_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      drive_low_q <= drive_low_d;
    end
  end

  // Open drain: never drive the line high.
  assign dht_io = drive_low_q ? 1'b0 : 1'bz;

  assign humidity_inc    = out_q.hum_inc;
  assign humidity_dec    = out_q.hum_dec;
  assign temperature_inc = out_q.temp_inc;
  assign temperature_dec = out_q.temp_dec;
  assign busy            = busy_q;
  assign valid           = valid_q;
  assign error           = error_q;

endmodule
